// File: rtl/tt_pkg.sv
// Shared definitions for the time-triggered forwarding path: control codes,
// ingress/egress state encodings and the one-hot port decode used by checker and buffers.
package tt_pkg;

   localparam logic [7:0] CTRL_EOF = 8'h01;

   typedef enum logic [1:0] {
      IN_IDLE  = 2'd0,
      IN_FRAME = 2'd1,
      IN_DROP  = 2'd2
   } in_state_e;

   typedef enum logic [1:0] {
      EG_IDLE = 2'd0,
      EG_WAIT = 2'd1,
      EG_SEND = 2'd2
   } eg_state_e;

   // Ports are numbered 1..4; bit (port_id-1) of the one-hot select addresses that port.
   function automatic logic port_selected(input logic [3:0] port_onehot, input int port_id);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (port_id == i + 1) hit = port_onehot[i];
      end
      return hit;
   endfunction

endpackage

// File: rtl/tt_sync_ram.sv
// Simple dual-port frame memory: one write port, one read port with a registered output.
// The array carries no reset so it maps onto block RAM.
module tt_sync_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 72
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tt_port_buffer.sv
// Per-(port, buffer) time-triggered frame store: captures frames steered here by the
// window checker and plays each one out to the egress MAC once its send time is reached.
module tt_port_buffer
   import tt_pkg::*;
#(
   parameter int PORT_ID         = 1,
   parameter int BUFFER_ID       = 0,
   parameter int ADDR_WIDTH      = 8,
   parameter int MAX_FRAME_WORDS = 32,
   parameter int MAX_FRAMES      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] in_buffer_data,
   input  logic [7:0]  in_buffer_ctrl,
   input  logic        in_buffer_wr,
   input  logic [3:0]  in_switch_port,
   input  logic [3:0]  in_switch_buffer,
   output logic        out_buffer_rdy,
   input  logic [63:0] in_global_time,
   input  logic [63:0] in_send_time,
   input  logic        in_send_en,
   input  logic        in_mac_rdy,
   output logic [63:0] out_mac_data,
   output logic [7:0]  out_mac_ctrl,
   output logic        out_mac_wr,
   output logic [2:0]  out_frame_count,
   output logic        out_overflow
);

   localparam int PTR_W  = ADDR_WIDTH + 1;
   localparam int CNT_W  = $clog2(MAX_FRAME_WORDS + 1);
   localparam int FIDX_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W-1:0]  USED_LIMIT = PTR_W'((2**ADDR_WIDTH) - MAX_FRAME_WORDS);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  WORDS_MAX  = CNT_W'(MAX_FRAME_WORDS);
   localparam logic [2:0]        FRAMES_MAX = 3'(MAX_FRAMES);
   localparam logic [3:0]        BUF_ID     = 4'(BUFFER_ID);
   localparam logic [FIDX_W-1:0] FIDX_ONE   = FIDX_W'(1);
   localparam logic [FIDX_W-1:0] FIDX_LAST  = FIDX_W'(MAX_FRAMES - 1);

   in_state_e         in_state_q, in_state_d;
   eg_state_e         eg_state_q, eg_state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  cmt_ptr_q, cmt_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [2:0]        frame_cnt_q, frame_cnt_d;
   logic              ovf_q, ovf_d;
   logic              mac_wr_q;
   logic [FIDX_W-1:0] end_head_q, end_head_d;
   logic [FIDX_W-1:0] end_tail_q, end_tail_d;
   logic [PTR_W-1:0]  end_ptr_q [MAX_FRAMES];

   logic              sel;
   logic              buf_rdy;
   logic              accept;
   logic              is_eof;
   logic              ram_we;
   logic              commit;
   logic              rel_frame;
   logic              rd_issue;
   logic [PTR_W-1:0]  used;
   logic [PTR_W-1:0]  head_end;
   logic [71:0]       ram_rd;

   assign sel    = port_selected(in_switch_port, PORT_ID) && (in_switch_buffer == BUF_ID);
   assign used   = wr_ptr_q - rd_ptr_q;
   assign accept = sel && in_buffer_wr && buf_rdy;
   assign is_eof = (in_buffer_ctrl == CTRL_EOF);
   assign ram_we = accept && (in_state_q != IN_DROP);

   // A new frame is only admitted when a maximum-length frame is guaranteed to fit.
   always_comb begin
      buf_rdy = 1'b1;
      if (in_state_q == IN_IDLE) begin
         buf_rdy = (used <= USED_LIMIT) && (frame_cnt_q < FRAMES_MAX);
      end
   end

   always_comb begin
      in_state_d = in_state_q;
      wr_ptr_d   = wr_ptr_q;
      cmt_ptr_d  = cmt_ptr_q;
      word_cnt_d = word_cnt_q;
      ovf_d      = 1'b0;
      commit     = 1'b0;
      if (accept) begin
         case (in_state_q)
            IN_IDLE: begin
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               if (is_eof) begin
                  commit    = 1'b1;
                  cmt_ptr_d = wr_ptr_q + PTR_ONE;
               end else begin
                  word_cnt_d = CNT_ONE;
                  in_state_d = IN_FRAME;
               end
            end
            IN_FRAME: begin
               word_cnt_d = word_cnt_q + CNT_ONE;
               if (is_eof) begin
                  wr_ptr_d   = wr_ptr_q + PTR_ONE;
                  cmt_ptr_d  = wr_ptr_q + PTR_ONE;
                  commit     = 1'b1;
                  in_state_d = IN_IDLE;
               end else if (word_cnt_q + CNT_ONE == WORDS_MAX) begin
                  // Oversize: forget the partial frame and swallow the rest of it.
                  wr_ptr_d   = cmt_ptr_q;
                  ovf_d      = 1'b1;
                  in_state_d = IN_DROP;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
               end
            end
            IN_DROP: begin
               if (is_eof) in_state_d = IN_IDLE;
            end
            default: in_state_d = IN_IDLE;
         endcase
      end
   end

   assign end_tail_d = !commit ? end_tail_q :
                       (end_tail_q == FIDX_LAST) ? '0 : end_tail_q + FIDX_ONE;

   // Frame end pointers let the read side stop on the EOF word without a lookahead read.
   assign head_end = end_ptr_q[end_head_q];

   always_comb begin
      eg_state_d = eg_state_q;
      rd_ptr_d   = rd_ptr_q;
      end_head_d = end_head_q;
      rd_issue   = 1'b0;
      rel_frame  = 1'b0;
      case (eg_state_q)
         EG_IDLE: begin
            if (frame_cnt_q != 3'd0) eg_state_d = EG_WAIT;
         end
         EG_WAIT: begin
            if (in_send_en && (in_global_time >= in_send_time)) eg_state_d = EG_SEND;
         end
         EG_SEND: begin
            if (in_mac_rdy) begin
               rd_issue = 1'b1;
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               if (rd_ptr_q + PTR_ONE == head_end) begin
                  rel_frame  = 1'b1;
                  eg_state_d = EG_IDLE;
                  end_head_d = (end_head_q == FIDX_LAST) ? '0 : end_head_q + FIDX_ONE;
               end
            end
         end
         default: eg_state_d = EG_IDLE;
      endcase
   end

   always_comb begin
      case ({commit, rel_frame})
         2'b10:   frame_cnt_d = frame_cnt_q + 3'd1;
         2'b01:   frame_cnt_d = frame_cnt_q - 3'd1;
         default: frame_cnt_d = frame_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_state_q  <= IN_IDLE;
         eg_state_q  <= EG_IDLE;
         wr_ptr_q    <= '0;
         cmt_ptr_q   <= '0;
         rd_ptr_q    <= '0;
         word_cnt_q  <= '0;
         frame_cnt_q <= '0;
         ovf_q       <= 1'b0;
         mac_wr_q    <= 1'b0;
         end_head_q  <= '0;
         end_tail_q  <= '0;
         for (int i = 0; i < MAX_FRAMES; i++) end_ptr_q[i] <= '0;
      end else begin
         in_state_q  <= in_state_d;
         eg_state_q  <= eg_state_d;
         wr_ptr_q    <= wr_ptr_d;
         cmt_ptr_q   <= cmt_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         word_cnt_q  <= word_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         ovf_q       <= ovf_d;
         mac_wr_q    <= rd_issue;
         end_head_q  <= end_head_d;
         end_tail_q  <= end_tail_d;
         if (commit) end_ptr_q[end_tail_q] <= cmt_ptr_d;
      end
   end

   tt_sync_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (72)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (ram_we),
      .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data_i ({in_buffer_ctrl, in_buffer_data}),
      .rd_en_i   (rd_issue),
      .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data_o (ram_rd)
   );

   // The RAM output register has no reset, so gate it with the registered valid.
   assign out_mac_wr      = mac_wr_q;
   assign out_mac_data    = mac_wr_q ? ram_rd[63:0]  : 64'd0;
   assign out_mac_ctrl    = mac_wr_q ? ram_rd[71:64] : 8'd0;
   assign out_buffer_rdy  = buf_rdy;
   assign out_frame_count = frame_cnt_q;
   assign out_overflow    = ovf_q;

endmodule

// File: tb/tb_tt_port_buffer.sv
// Directed bench for tt_port_buffer: single frame timing, deselection, oversize drop,
// full gating, backpressure across pointer wrap, and reset in the middle of traffic.
module tb_tt_port_buffer;

   logic        clk;
   logic        rst_n;
   logic [63:0] in_buffer_data;
   logic [7:0]  in_buffer_ctrl;
   logic        in_buffer_wr;
   logic [3:0]  in_switch_port;
   logic [3:0]  in_switch_buffer;
   logic        out_buffer_rdy;
   logic [63:0] in_global_time;
   logic [63:0] in_send_time;
   logic        in_send_en;
   logic        in_mac_rdy;
   logic [63:0] out_mac_data;
   logic [7:0]  out_mac_ctrl;
   logic        out_mac_wr;
   logic [2:0]  out_frame_count;
   logic        out_overflow;

   int n_assert = 0;
   int n_fail   = 0;
   int ovf_cnt  = 0;
   int bp_cnt   = 0;
   bit bp_on    = 0;
   logic [71:0] got [$];
   logic [71:0] exp_q [$];

   tt_port_buffer #(
      .PORT_ID         (2),
      .BUFFER_ID       (1),
      .ADDR_WIDTH      (4),
      .MAX_FRAME_WORDS (4),
      .MAX_FRAMES      (4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_buffer_data   (in_buffer_data),
      .in_buffer_ctrl   (in_buffer_ctrl),
      .in_buffer_wr     (in_buffer_wr),
      .in_switch_port   (in_switch_port),
      .in_switch_buffer (in_switch_buffer),
      .out_buffer_rdy   (out_buffer_rdy),
      .in_global_time   (in_global_time),
      .in_send_time     (in_send_time),
      .in_send_en       (in_send_en),
      .in_mac_rdy       (in_mac_rdy),
      .out_mac_data     (out_mac_data),
      .out_mac_ctrl     (out_mac_ctrl),
      .out_mac_wr       (out_mac_wr),
      .out_frame_count  (out_frame_count),
      .out_overflow     (out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: advance to the next falling edge and record egress/overflow activity.
   task automatic cyc();
      @(negedge clk);
      if (out_mac_wr === 1'b1) got.push_back({out_mac_ctrl, out_mac_data});
      if (out_overflow === 1'b1) ovf_cnt++;
      if (bp_on) begin
         bp_cnt++;
         in_mac_rdy = (((bp_cnt / 3) % 2) == 0);
      end
   endtask

   task automatic put(input logic [63:0] d, input logic [7:0] c);
      in_buffer_data = d;
      in_buffer_ctrl = c;
      in_buffer_wr   = 1'b1;
      cyc();
      in_buffer_wr   = 1'b0;
   endtask

   task automatic drain(input int n);
      in_send_en     = 1'b1;
      in_send_time   = 64'd0;
      in_global_time = 64'd10000;
      repeat (n) cyc();
      in_send_en = 1'b0;
   endtask

   task automatic cmp_got(input string tag);
      chk({tag, "_len"}, 72'(got.size()), 72'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got.size()) chk(tag, got[i], exp_q[i]);
      end
   endtask

   initial begin
      int first_i;
      int wcnt;
      int w;
      logic [63:0] d;

      rst_n            = 1'b0;
      in_buffer_data   = '0;
      in_buffer_ctrl   = '0;
      in_buffer_wr     = 1'b0;
      in_switch_port   = 4'b0010;
      in_switch_buffer = 4'd1;
      in_global_time   = '0;
      in_send_time     = '0;
      in_send_en       = 1'b0;
      in_mac_rdy       = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_rdy",   72'(out_buffer_rdy), 72'(1));
      chk("rst_wr",    72'(out_mac_wr), 72'(0));
      chk("rst_data",  72'(out_mac_data), 72'(0));
      chk("rst_ctrl",  72'(out_mac_ctrl), 72'(0));
      chk("rst_count", 72'(out_frame_count), 72'(0));
      chk("rst_ovf",   72'(out_overflow), 72'(0));
      rst_n = 1'b1;
      cyc();

      // Single frame released at global time 600
      got.delete();
      put(64'd500, 8'h00);
      put(64'hA, 8'h00);
      put(64'hB, 8'h01);
      chk("single_count", 72'(out_frame_count), 72'(1));
      in_send_time = 64'd600;
      in_send_en   = 1'b1;
      first_i      = -1;
      wcnt         = 0;
      for (int i = 0; i < 20; i++) begin
         in_global_time = 64'd590 + 64'(i);
         cyc();
         if (out_mac_wr === 1'b1) begin
            wcnt++;
            if (first_i < 0) first_i = i;
         end
      end
      in_send_en = 1'b0;
      chk("single_first_wr", 72'(first_i), 72'(11));
      chk("single_wr_cycles", 72'(wcnt), 72'(3));
      exp_q = '{{8'h00, 64'd500}, {8'h00, 64'hA}, {8'h01, 64'hB}};
      cmp_got("single_word");
      chk("single_count_after", 72'(out_frame_count), 72'(0));

      // Deselected traffic: wrong port, then right port with wrong buffer
      got.delete();
      ovf_cnt = 0;
      in_switch_port = 4'b0100;
      put(64'd500, 8'h00); put(64'hA, 8'h00); put(64'hB, 8'h01);
      in_switch_port = 4'b0010;
      in_switch_buffer = 4'd2;
      put(64'd500, 8'h00); put(64'hA, 8'h00); put(64'hB, 8'h01);
      in_switch_buffer = 4'd1;
      chk("desel_count", 72'(out_frame_count), 72'(0));
      drain(10);
      chk("desel_no_egress", 72'(got.size()), 72'(0));
      chk("desel_no_ovf", 72'(ovf_cnt), 72'(0));

      // Oversize: 6 words with EOF on word 6, overflow pulse after word 4
      ovf_cnt = 0;
      for (int k = 1; k <= 6; k++) begin
         put(64'h700 + 64'(k), (k == 6) ? 8'h01 : 8'h00);
         chk($sformatf("ovf_pulse_w%0d", k), 72'(out_overflow), 72'((k == 4) ? 1 : 0));
      end
      chk("ovf_once", 72'(ovf_cnt), 72'(1));
      chk("ovf_count", 72'(out_frame_count), 72'(0));
      got.delete();
      put(64'd700, 8'h00);
      put(64'hC0FFEE, 8'h01);
      chk("ovf_next_count", 72'(out_frame_count), 72'(1));
      drain(15);
      exp_q = '{{8'h00, 64'd700}, {8'h01, 64'hC0FFEE}};
      cmp_got("ovf_next_word");

      // Full: four frames gate ingress until one is released
      got.delete();
      exp_q.delete();
      for (int f = 0; f < 4; f++) begin
         put(64'h100 + 64'(f), 8'h00);
         put(64'h200 + 64'(f), 8'h01);
         exp_q.push_back({8'h00, 64'h100 + 64'(f)});
         exp_q.push_back({8'h01, 64'h200 + 64'(f)});
      end
      chk("full_count", 72'(out_frame_count), 72'(4));
      chk("full_rdy_low", 72'(out_buffer_rdy), 72'(0));
      put(64'hDEAD, 8'h01);
      chk("full_ignored", 72'(out_frame_count), 72'(4));
      in_send_en     = 1'b1;
      in_send_time   = 64'd0;
      in_global_time = 64'd10000;
      w = 0;
      while (out_frame_count !== 3'd3 && w < 20) begin
         cyc();
         w++;
      end
      in_send_en = 1'b0;
      chk("full_release_seen", 72'(w < 20), 72'(1));
      chk("full_rdy_after_release", 72'(out_buffer_rdy), 72'(1));
      drain(40);
      chk("full_drained", 72'(out_frame_count), 72'(0));
      cmp_got("full_word");

      // Backpressure across pointer wrap: 12 three-word frames through a 16-word store
      got.delete();
      exp_q.delete();
      bp_on          = 1;
      bp_cnt         = 0;
      in_send_en     = 1'b1;
      in_send_time   = 64'd0;
      in_global_time = 64'd5000;
      for (int f = 0; f < 12; f++) begin
         w = 0;
         while (out_buffer_rdy !== 1'b1 && w < 100) begin
            cyc();
            w++;
         end
         chk("wrap_rdy_wait", 72'(w < 100), 72'(1));
         for (int k = 0; k < 3; k++) begin
            d = 64'h5000_0000 + 64'(f * 16 + k);
            put(d, (k == 2) ? 8'h01 : 8'h00);
            exp_q.push_back({(k == 2) ? 8'h01 : 8'h00, d});
         end
      end
      w = 0;
      while (got.size() < 36 && w < 300) begin
         cyc();
         w++;
      end
      repeat (5) cyc();
      bp_on      = 0;
      in_mac_rdy = 1'b1;
      in_send_en = 1'b0;
      cmp_got("wrap_word");
      chk("wrap_count", 72'(out_frame_count), 72'(0));

      // Reset while one frame is being sent and another is half received
      got.delete();
      in_mac_rdy     = 1'b0;
      in_send_en     = 1'b1;
      in_send_time   = 64'd0;
      in_global_time = 64'd5000;
      put(64'h900, 8'h00); put(64'h901, 8'h00); put(64'h902, 8'h00); put(64'h903, 8'h01);
      put(64'h950, 8'h00);
      put(64'h951, 8'h00);
      cyc();
      in_mac_rdy = 1'b1;
      cyc();
      chk("pre_rst_wr", 72'(out_mac_wr), 72'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr",    72'(out_mac_wr), 72'(0));
      chk("mid_rst_data",  72'(out_mac_data), 72'(0));
      chk("mid_rst_ctrl",  72'(out_mac_ctrl), 72'(0));
      chk("mid_rst_rdy",   72'(out_buffer_rdy), 72'(1));
      chk("mid_rst_count", 72'(out_frame_count), 72'(0));
      chk("mid_rst_ovf",   72'(out_overflow), 72'(0));
      cyc();
      cyc();
      rst_n = 1'b1;
      got.delete();
      put(64'hAB0, 8'h00);
      put(64'hAB1, 8'h01);
      chk("post_rst_count", 72'(out_frame_count), 72'(1));
      drain(15);
      exp_q = '{{8'h00, 64'hAB0}, {8'h01, 64'hAB1}};
      cmp_got("post_rst_word");
      chk("post_rst_count_after", 72'(out_frame_count), 72'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
